// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and defaults for the mux select scanner.
package mux_sel_scanner_pkg;

  localparam int unsigned SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int unsigned data_width(input int unsigned sel_w);
    return 32'(1) << sel_w;
  endfunction

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Control, mux-tree and serial signals between the scanner and its parent.
interface mux_sel_scanner_if
  import mux_sel_scanner_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
);

  localparam int unsigned DATA_W = data_width(SEL_W);

  logic              start;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] mux_data;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic              ser_valid;
  logic              ser_bit;
  logic              ser_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] captured;

  modport master (
    output start, load_data, mux_out, ser_ready,
    input  mux_data, sel, ser_valid, ser_bit, busy, done, captured
  );

  modport slave (
    input  start, load_data, mux_out, ser_ready,
    output mux_data, sel, ser_valid, ser_bit, busy, done, captured
  );

endinterface

// File: rtl/mux_sel_scanner.sv
// Steps the select lines of an external mux tree and serialises its output
// on a valid/ready port, LSB (sel=0) first, rebuilding the word as it goes.
module mux_sel_scanner
  import mux_sel_scanner_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_scanner_if.slave   bus
);

  localparam int unsigned DATA_W = data_width(SEL_W);

  state_e            state_q,     state_d;
  logic [DATA_W-1:0] mux_data_q,  mux_data_d;
  logic [SEL_W-1:0]  sel_q,       sel_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_bit_q,   ser_bit_d;
  logic [DATA_W-1:0] captured_q,  captured_d;
  logic              done_q,      done_d;
  logic              busy_q,      busy_d;

  // Next-state and datapath: everything holds unless the current state moves it.
  always_comb begin
    state_d     = state_q;
    mux_data_d  = mux_data_q;
    sel_d       = sel_q;
    ser_valid_d = ser_valid_q;
    ser_bit_d   = ser_bit_q;
    captured_d  = captured_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mux_data_d = bus.load_data;
          sel_d      = '0;
          captured_d = '0;
          state_d    = SAMPLE;
        end
      end
      SAMPLE: begin
        ser_bit_d         = bus.mux_out;
        captured_d[sel_q] = bus.mux_out;
        ser_valid_d       = 1'b1;
        state_d           = SEND;
      end
      SEND: begin
        if (bus.ser_ready) begin
          ser_valid_d = 1'b0;
          if (sel_q == SEL_W'(DATA_W - 1)) begin
            state_d = DONE;
          end else begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = SAMPLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the state they describe.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_data_q  <= '0;
      sel_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      captured_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_data_q  <= mux_data_d;
      sel_q       <= sel_d;
      ser_valid_q <= ser_valid_d;
      ser_bit_q   <= ser_bit_d;
      captured_q  <= captured_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mux_data  = mux_data_q;
  assign bus.sel       = sel_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.captured  = captured_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule
